// File: rtl/rx_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// rx_cmd_ctrl
// Command frame decoder that sits right after the bus synchronizer. It takes
// one byte per rx_valid strobe, decodes register-write, register-read and ALU
// frames, drives the register-file and ALU ports, and hands read/ALU results
// back to the TX path over a valid/ready handshake.
//
// Frames (first byte is the opcode, seen in IDLE):
//   0xAA WR     ADDR, DATA    -> reg_wr_en pulse
//   0xBB RD     ADDR          -> reg_rd_en pulse, wait reg_rd_valid, 1 tx byte
//   0xCC ALU    A, B, FUN     -> A written to addr 0, B to addr 1, alu_en,
//                                wait alu_valid, 2 tx bytes (low, then high)
//   0xDD ALUNOP FUN           -> as ALU without the operand writes
//
// Ports:
//   CLK, RST                      clock, asynchronous active-low reset
//   rx_data, rx_valid             incoming byte and its one-cycle strobe
//   reg_addr, reg_wr_data         register-file address / write data
//   reg_wr_en, reg_rd_en          one-cycle register strobes
//   reg_rd_data, reg_rd_valid     register read return
//   alu_fun, alu_en               ALU function code and one-cycle start
//   alu_out, alu_valid            ALU result return
//   tx_data, tx_valid, tx_ready   response byte handshake
//   cmd_err                       one-cycle pulse: bad opcode, dropped byte,
//                                 or partial-frame timeout
//
// Build option:
//   FRAME_TIMEOUT_EN  when defined, a partial frame (WR_*, RD_ADDR, ALU_A/B/FUN)
//                     that sees no byte for TIMEOUT cycles is aborted to IDLE
//                     with a cmd_err pulse. Wait and TX states never time out.
//                     When undefined, TIMEOUT is unused.
// -----------------------------------------------------------------------------
module rx_cmd_ctrl #(
  parameter int BUS_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [BUS_WIDTH-1:0]   rx_data,
  input  logic                   rx_valid,
  output logic [ADDR_WIDTH-1:0]  reg_addr,
  output logic [BUS_WIDTH-1:0]   reg_wr_data,
  output logic                   reg_wr_en,
  output logic                   reg_rd_en,
  input  logic [BUS_WIDTH-1:0]   reg_rd_data,
  input  logic                   reg_rd_valid,
  output logic [3:0]             alu_fun,
  output logic                   alu_en,
  input  logic [2*BUS_WIDTH-1:0] alu_out,
  input  logic                   alu_valid,
  output logic [BUS_WIDTH-1:0]   tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   cmd_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
    S_ALU_A, S_ALU_B, S_ALU_FUN, S_ALU_WAIT, S_TX_LO, S_TX_HI
  } state_t;

  localparam logic [BUS_WIDTH-1:0] OP_WR     = BUS_WIDTH'(8'hAA);
  localparam logic [BUS_WIDTH-1:0] OP_RD     = BUS_WIDTH'(8'hBB);
  localparam logic [BUS_WIDTH-1:0] OP_ALU    = BUS_WIDTH'(8'hCC);
  localparam logic [BUS_WIDTH-1:0] OP_ALUNOP = BUS_WIDTH'(8'hDD);

  state_t               state;
  logic [BUS_WIDTH-1:0] result_hi;  // upper ALU byte, sent from TX_HI
  logic                 result_alu; // response has a second (high) byte

`ifdef FRAME_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] idle_cnt;
  logic             timeout_hit;

  // The TIMEOUT-th consecutive byte-less cycle in a partial-frame state aborts.
  always_comb begin
    timeout_hit = 1'b0;
    if (!rx_valid && idle_cnt == CNT_LAST &&
        state inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_ALU_A, S_ALU_B, S_ALU_FUN})
      timeout_hit = 1'b1;
  end

  // Saturates in the exempt states so it never wraps while waiting on TX/ALU.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      idle_cnt <= '0;
    else if (state == S_IDLE || rx_valid || timeout_hit)
      idle_cnt <= '0;
    else if (idle_cnt != CNT_LAST)
      idle_cnt <= idle_cnt + CNT_W'(1);
  end
`endif

  // NOTE: every output is a flop assigned with <=, so strobes appear exactly one
  // cycle after the byte that triggers them and never glitch.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      alu_fun     <= '0;
      alu_en      <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      cmd_err     <= 1'b0;
      result_hi   <= '0;
      result_alu  <= 1'b0;
    end else begin
      // NOTE: strobes default low each cycle; the case below raises them for
      // one cycle only.
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      alu_en    <= 1'b0;
      cmd_err   <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      if (timeout_hit) begin
        state   <= S_IDLE;
        cmd_err <= 1'b1;
      end else
`endif
      case (state)
        S_IDLE: if (rx_valid) begin
          case (rx_data)
            OP_WR:     state <= S_WR_ADDR;
            OP_RD:     state <= S_RD_ADDR;
            OP_ALU:    state <= S_ALU_A;
            OP_ALUNOP: state <= S_ALU_FUN;
            default:   cmd_err <= 1'b1;
          endcase
        end
        S_WR_ADDR: if (rx_valid) begin
          reg_addr <= rx_data[ADDR_WIDTH-1:0];
          state    <= S_WR_DATA;
        end
        S_WR_DATA: if (rx_valid) begin
          reg_wr_data <= rx_data;
          reg_wr_en   <= 1'b1;
          state       <= S_IDLE;
        end
        S_RD_ADDR: if (rx_valid) begin
          reg_addr  <= rx_data[ADDR_WIDTH-1:0];
          reg_rd_en <= 1'b1;
          state     <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          cmd_err <= rx_valid;
          if (reg_rd_valid) begin
            tx_data    <= reg_rd_data;
            tx_valid   <= 1'b1;
            result_hi  <= '0;
            result_alu <= 1'b0;
            state      <= S_TX_LO;
          end
        end
        S_ALU_A: if (rx_valid) begin
          reg_addr    <= ADDR_WIDTH'(0);
          reg_wr_data <= rx_data;
          reg_wr_en   <= 1'b1;
          state       <= S_ALU_B;
        end
        S_ALU_B: if (rx_valid) begin
          reg_addr    <= ADDR_WIDTH'(1);
          reg_wr_data <= rx_data;
          reg_wr_en   <= 1'b1;
          state       <= S_ALU_FUN;
        end
        S_ALU_FUN: if (rx_valid) begin
          alu_fun <= rx_data[3:0];
          alu_en  <= 1'b1;
          state   <= S_ALU_WAIT;
        end
        S_ALU_WAIT: begin
          cmd_err <= rx_valid;
          if (alu_valid) begin
            tx_data    <= alu_out[BUS_WIDTH-1:0];
            tx_valid   <= 1'b1;
            result_hi  <= alu_out[2*BUS_WIDTH-1:BUS_WIDTH];
            result_alu <= 1'b1;
            state      <= S_TX_LO;
          end
        end
        // tx_valid is already high in both TX states; hold data until accepted.
        S_TX_LO: begin
          cmd_err <= rx_valid;
          if (tx_ready) begin
            if (result_alu) begin
              tx_data <= result_hi;
              state   <= S_TX_HI;
            end else begin
              tx_valid <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end
        S_TX_HI: begin
          cmd_err <= rx_valid;
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_cmd_ctrl
// Self-checking bench for rx_cmd_ctrl: a table of per-cycle vectors covering
// WR, RD, ALU and ALUNOP frames, unknown opcodes and ignored returns, followed
// by hand-written sequences for TX back-pressure with a dropped byte, reset in
// the middle of a frame, and (with FRAME_TIMEOUT_EN) the partial-frame timeout.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the
// rising edge, so each vector's expectations are the registered response to
// that vector's inputs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rx_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [3:0]  reg_addr;
  logic [7:0]  reg_wr_data;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [7:0]  reg_rd_data;
  logic        reg_rd_valid;
  logic [3:0]  alu_fun;
  logic        alu_en;
  logic [15:0] alu_out;
  logic        alu_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        cmd_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  rx_cmd_ctrl #(.BUS_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .reg_addr     (reg_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_wr_en    (reg_wr_en),
    .reg_rd_en    (reg_rd_en),
    .reg_rd_data  (reg_rd_data),
    .reg_rd_valid (reg_rd_valid),
    .alu_fun      (alu_fun),
    .alu_en       (alu_en),
    .alu_out      (alu_out),
    .alu_valid    (alu_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .cmd_err      (cmd_err)
  );

  typedef struct {
    logic        rxv;
    logic [7:0]  rxd;
    logic        rdv;
    logic [7:0]  rdd;
    logic        av;
    logic [15:0] ao;
    logic        rdy;
    logic        e_wr;
    logic        e_rd;
    logic        e_alu;
    logic        e_txv;
    logic        e_err;
    logic [3:0]  e_addr;
    logic [7:0]  e_wdata;
    logic [3:0]  e_fun;
    logic [7:0]  e_txd;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic rxv, input logic [7:0] rxd,
    input logic rdv, input logic [7:0] rdd,
    input logic av,  input logic [15:0] ao, input logic rdy,
    input logic e_wr, input logic e_rd, input logic e_alu,
    input logic e_txv, input logic e_err,
    input logic [3:0] e_addr, input logic [7:0] e_wdata,
    input logic [3:0] e_fun, input logic [7:0] e_txd);
    vec_t v;
    v.rxv = rxv; v.rxd = rxd; v.rdv = rdv; v.rdd = rdd;
    v.av = av; v.ao = ao; v.rdy = rdy;
    v.e_wr = e_wr; v.e_rd = e_rd; v.e_alu = e_alu;
    v.e_txv = e_txv; v.e_err = e_err;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_fun = e_fun; v.e_txd = e_txd;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  // One clock: drive on the falling edge, settle just after the rising edge.
  task automatic drive(input logic rxv, input logic [7:0] rxd,
                       input logic rdv, input logic [7:0] rdd,
                       input logic av, input logic [15:0] ao, input logic rdy);
    @(negedge CLK);
    rx_valid = rxv; rx_data = rxd;
    reg_rd_valid = rdv; reg_rd_data = rdd;
    alu_valid = av; alu_out = ao;
    tx_ready = rdy;
    @(posedge CLK);
    #1;
  endtask

  task automatic byte_in(input logic [7:0] b, input logic rdy);
    drive(1'b1, b, 1'b0, 8'h00, 1'b0, 16'h0000, rdy);
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, rdy);
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v.rxv, v.rxd, v.rdv, v.rdd, v.av, v.ao, v.rdy);
    check($sformatf("v%0d reg_wr_en", idx), 16'(reg_wr_en), 16'(v.e_wr));
    check($sformatf("v%0d reg_rd_en", idx), 16'(reg_rd_en), 16'(v.e_rd));
    check($sformatf("v%0d alu_en",    idx), 16'(alu_en),    16'(v.e_alu));
    check($sformatf("v%0d tx_valid",  idx), 16'(tx_valid),  16'(v.e_txv));
    check($sformatf("v%0d cmd_err",   idx), 16'(cmd_err),   16'(v.e_err));
    if (v.e_wr || v.e_rd)
      check($sformatf("v%0d reg_addr", idx), 16'(reg_addr), 16'(v.e_addr));
    if (v.e_wr)
      check($sformatf("v%0d reg_wr_data", idx), 16'(reg_wr_data), 16'(v.e_wdata));
    if (v.e_alu)
      check($sformatf("v%0d alu_fun", idx), 16'(alu_fun), 16'(v.e_fun));
    if (v.e_txv)
      check($sformatf("v%0d tx_data", idx), 16'(tx_data), 16'(v.e_txd));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " reg_wr_en"},   16'(reg_wr_en),   16'h0);
    check({tag, " reg_rd_en"},   16'(reg_rd_en),   16'h0);
    check({tag, " alu_en"},      16'(alu_en),      16'h0);
    check({tag, " tx_valid"},    16'(tx_valid),    16'h0);
    check({tag, " cmd_err"},     16'(cmd_err),     16'h0);
    check({tag, " reg_addr"},    16'(reg_addr),    16'h0);
    check({tag, " reg_wr_data"}, 16'(reg_wr_data), 16'h0);
    check({tag, " alu_fun"},     16'(alu_fun),     16'h0);
    check({tag, " tx_data"},     16'(tx_data),     16'h0);
  endtask

  initial begin
    //          rxv rxd    rdv rdd    av  ao        rdy  wr rd alu txv err addr wdata fun txd
    // WR frame AA,05,3C
    vecs[0]  = mk(1, 8'hAA, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 0,  0,  0,  4'h0, 8'h00, 4'h0, 8'h00);
    vecs[1]  = mk(1, 8'h05, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 0,  0,  0,  4'h0, 8'h00, 4'h0, 8'h00);
    vecs[2]  = mk(1, 8'h3C, 0, 8'h00, 0, 16'h0000, 1,   1, 0, 0,  0,  0,  4'h5, 8'h3C, 4'h0, 8'h00);
    vecs[3]  = mk(0, 8'h00, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 0,  0,  0,  4'h0, 8'h00, 4'h0, 8'h00);
    // RD frame BB,07; read returns 9E
    vecs[4]  = mk(1, 8'hBB, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 0,  0,  0,  4'h0, 8'h00, 4'h0, 8'h00);
    vecs[5]  = mk(1, 8'h07, 0, 8'h00, 0, 16'h0000, 1,   0, 1, 0,  0,  0,  4'h7, 8'h00, 4'h0, 8'h00);
    vecs[6]  = mk(0, 8'h00, 0, 8'h00, 1, 16'h1234, 1,   0, 0, 0,  0,  0,  4'h0, 8'h00, 4'h0, 8'h00);
    vecs[7]  = mk(0, 8'h00, 1, 8'h9E, 0, 16'h0000, 1,   0, 0, 0,  1,  0,  4'h0, 8'h00, 4'h0, 8'h9E);
    vecs[8]  = mk(0, 8'h00, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 0,  0,  0,  4'h0, 8'h00, 4'h0, 8'h00);
    // ALU frame CC,12,34,02; result 0246
    vecs[9]  = mk(1, 8'hCC, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 0,  0,  0,  4'h0, 8'h00, 4'h0, 8'h00);
    vecs[10] = mk(1, 8'h12, 0, 8'h00, 0, 16'h0000, 1,   1, 0, 0,  0,  0,  4'h0, 8'h12, 4'h0, 8'h00);
    vecs[11] = mk(1, 8'h34, 0, 8'h00, 0, 16'h0000, 1,   1, 0, 0,  0,  0,  4'h1, 8'h34, 4'h0, 8'h00);
    vecs[12] = mk(1, 8'h02, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 1,  0,  0,  4'h0, 8'h00, 4'h2, 8'h00);
    vecs[13] = mk(0, 8'h00, 0, 8'h00, 1, 16'h0246, 1,   0, 0, 0,  1,  0,  4'h0, 8'h00, 4'h0, 8'h46);
    vecs[14] = mk(0, 8'h00, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 0,  1,  0,  4'h0, 8'h00, 4'h0, 8'h02);
    vecs[15] = mk(0, 8'h00, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 0,  0,  0,  4'h0, 8'h00, 4'h0, 8'h00);
    // Unknown opcode 55, then WR AA,01,FF
    vecs[16] = mk(1, 8'h55, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 0,  0,  1,  4'h0, 8'h00, 4'h0, 8'h00);
    vecs[17] = mk(1, 8'hAA, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 0,  0,  0,  4'h0, 8'h00, 4'h0, 8'h00);
    vecs[18] = mk(1, 8'h01, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 0,  0,  0,  4'h0, 8'h00, 4'h0, 8'h00);
    vecs[19] = mk(1, 8'hFF, 0, 8'h00, 0, 16'h0000, 1,   1, 0, 0,  0,  0,  4'h1, 8'hFF, 4'h0, 8'h00);
    // ALUNOP DD,05; result ABCD
    vecs[20] = mk(1, 8'hDD, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 0,  0,  0,  4'h0, 8'h00, 4'h0, 8'h00);
    vecs[21] = mk(1, 8'h05, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 1,  0,  0,  4'h0, 8'h00, 4'h5, 8'h00);
    vecs[22] = mk(0, 8'h00, 0, 8'h00, 1, 16'hABCD, 1,   0, 0, 0,  1,  0,  4'h0, 8'h00, 4'h0, 8'hCD);
    vecs[23] = mk(0, 8'h00, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 0,  1,  0,  4'h0, 8'h00, 4'h0, 8'hAB);
    vecs[24] = mk(0, 8'h00, 0, 8'h00, 0, 16'h0000, 1,   0, 0, 0,  0,  0,  4'h0, 8'h00, 4'h0, 8'h00);
    // Returns outside their wait state are ignored
    vecs[25] = mk(0, 8'h00, 1, 8'h77, 0, 16'h0000, 1,   0, 0, 0,  0,  0,  4'h0, 8'h00, 4'h0, 8'h00);
    vecs[26] = mk(0, 8'h00, 0, 8'h00, 1, 16'h5A5A, 1,   0, 0, 0,  0,  0,  4'h0, 8'h00, 4'h0, 8'h00);

    RST = 1'b0;
    rx_valid = 1'b0; rx_data = '0;
    reg_rd_valid = 1'b0; reg_rd_data = '0;
    alu_valid = 1'b0; alu_out = '0;
    tx_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < NVEC; i++)
      apply(vecs[i], i);

    // RD response held under back-pressure with a byte injected mid-wait.
    byte_in(8'hBB, 1'b0);
    byte_in(8'h07, 1'b0);
    check("bp reg_rd_en", 16'(reg_rd_en), 16'h1);
    check("bp reg_addr",  16'(reg_addr),  16'h7);
    drive(1'b0, 8'h00, 1'b1, 8'h9E, 1'b0, 16'h0000, 1'b0);
    check("bp first tx_valid", 16'(tx_valid), 16'h1);
    check("bp first tx_data",  16'(tx_data),  16'h9E);
    for (int i = 0; i < 10; i++) begin
      drive(i == 4, 8'h42, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
      check($sformatf("bp hold%0d tx_valid", i), 16'(tx_valid), 16'h1);
      check($sformatf("bp hold%0d tx_data",  i), 16'(tx_data),  16'h9E);
      check($sformatf("bp hold%0d cmd_err",  i), 16'(cmd_err),  16'(i == 4));
    end
    idle(1'b1);
    check("bp sent tx_valid", 16'(tx_valid), 16'h0);
    check("bp sent cmd_err",  16'(cmd_err),  16'h0);
    byte_in(8'hAA, 1'b1);
    check("bp idle opcode cmd_err", 16'(cmd_err), 16'h0);
    byte_in(8'h02, 1'b1);
    byte_in(8'h5A, 1'b1);
    check("bp next wr_en",   16'(reg_wr_en),   16'h1);
    check("bp next addr",    16'(reg_addr),    16'h2);
    check("bp next wr_data", 16'(reg_wr_data), 16'h5A);

    // Asynchronous reset in the middle of an ALU frame.
    byte_in(8'hCC, 1'b1);
    byte_in(8'h12, 1'b1);
    check("pre-reset wr_en", 16'(reg_wr_en), 16'h1);
    #2 RST = 1'b0;
    #1;
    check_all_zero("mid reset");
    @(negedge CLK);
    RST = 1'b1;
    byte_in(8'hAA, 1'b1);
    check("post-reset opcode wr_en", 16'(reg_wr_en), 16'h0);
    byte_in(8'h04, 1'b1);
    byte_in(8'h22, 1'b1);
    check("post-reset wr_en",   16'(reg_wr_en),   16'h1);
    check("post-reset addr",    16'(reg_addr),    16'h4);
    check("post-reset wr_data", 16'(reg_wr_data), 16'h22);
    idle(1'b1);

`ifdef FRAME_TIMEOUT_EN
    // Partial WR frame aborted after 8 byte-less cycles.
    byte_in(8'hAA, 1'b1);
    byte_in(8'h03, 1'b1);
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      check($sformatf("to idle%0d cmd_err", i), 16'(cmd_err),   16'(i == 7));
      check($sformatf("to idle%0d wr_en",   i), 16'(reg_wr_en), 16'h0);
    end
    byte_in(8'hAA, 1'b1);
    check("to reopen cmd_err", 16'(cmd_err), 16'h0);
    byte_in(8'h03, 1'b1);
    byte_in(8'h11, 1'b1);
    check("to write wr_en",   16'(reg_wr_en),   16'h1);
    check("to write addr",    16'(reg_addr),    16'h3);
    check("to write wr_data", 16'(reg_wr_data), 16'h11);
    idle(1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
